imi_epoch_gen: RTL and testbench

- Imitator channel timing stage that sits directly upstream of the data-symbol wiper.
- Counts code-chip strobes from the channel code NCO and produces one-cycle epoch_pulse and sec2_pulse strobes.
- The wiper shifts data symbols on epoch_pulse and realigns its symbol packs on sec2_pulse.
- Also exposes the running chip and epoch indices for status readback.

---
 rtl/imi_epoch_gen_if.sv | 45 ++++
 rtl/imi_epoch_gen.sv | 118 +++++++++++
 tb/tb_imi_epoch_gen.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imi_epoch_gen_if.sv
// Bus interface for imi_epoch_gen: run control, chip strobe, epoch/sec2
// configuration, phase load, and the pulse/index/status outputs.
// Optional macro IMI_EPOCH_GEN_EXT_SYNC_EN adds the ext_sync strobe.
interface imi_epoch_gen_if #(
  parameter int CHIP_CNT_W  = 16,
  parameter int EPOCH_CNT_W = 12
) ();

  logic                   enable;
  logic                   chip_pulse;
  logic [CHIP_CNT_W-1:0]  chips_per_epoch;
  logic [EPOCH_CNT_W-1:0] epochs_per_sec2;
  logic                   load;
  logic [CHIP_CNT_W-1:0]  load_chip;
  logic [EPOCH_CNT_W-1:0] load_epoch;
`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
  logic                   ext_sync;
`endif
  logic                   epoch_pulse;
  logic                   sec2_pulse;
  logic [CHIP_CNT_W-1:0]  chip_idx;
  logic [EPOCH_CNT_W-1:0] epoch_idx;
  logic                   cfg_err;

  // Driver side: the channel control logic / testbench
  modport master (
`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
    output ext_sync,
`endif
    output enable, chip_pulse, chips_per_epoch, epochs_per_sec2,
    output load, load_chip, load_epoch,
    input  epoch_pulse, sec2_pulse, chip_idx, epoch_idx, cfg_err
  );

  // Epoch generator side
  modport slave (
`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
    input  ext_sync,
`endif
    input  enable, chip_pulse, chips_per_epoch, epochs_per_sec2,
    input  load, load_chip, load_epoch,
    output epoch_pulse, sec2_pulse, chip_idx, epoch_idx, cfg_err
  );

endinterface

// File: rtl/imi_epoch_gen.sv
// imi_epoch_gen: counts code-chip strobes into code epochs and 2 s intervals,
// producing registered one-cycle epoch_pulse / sec2_pulse strobes for the
// downstream data-symbol wiper, plus chip/epoch indices and a sticky
// configuration error flag.
// Optional macro IMI_EPOCH_GEN_EXT_SYNC_EN: external time-base sync strobe
// that zeroes both counters and fires both pulses on the following cycle.
module imi_epoch_gen #(
  parameter int CHIP_CNT_W  = 16,
  parameter int EPOCH_CNT_W = 12
) (
  input logic            clk,
  input logic            resetn,
  imi_epoch_gen_if.slave bus
);

  localparam logic [CHIP_CNT_W-1:0]  ChipOne  = CHIP_CNT_W'(1);
  localparam logic [EPOCH_CNT_W-1:0] EpochOne = EPOCH_CNT_W'(1);

  logic [CHIP_CNT_W-1:0]  chip_q, chip_d;
  logic [EPOCH_CNT_W-1:0] epoch_q, epoch_d;
  logic                   epoch_pulse_q, epoch_pulse_d;
  logic                   sec2_pulse_q, sec2_pulse_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   chips_zero, epochs_zero;
  logic [CHIP_CNT_W-1:0]  chip_last;
  logic [EPOCH_CNT_W-1:0] epoch_last;
  logic                   sync_hit;

  // A zero config makes (config-1) wrap to all ones; every use of the
  // *_last values is guarded by the matching *_zero flag.
  assign chips_zero  = (bus.chips_per_epoch == '0);
  assign epochs_zero = (bus.epochs_per_sec2 == '0);
  assign chip_last   = bus.chips_per_epoch - ChipOne;
  assign epoch_last  = bus.epochs_per_sec2 - EpochOne;

`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
  assign sync_hit = bus.ext_sync;
`else
  assign sync_hit = 1'b0;
`endif

  // Next-state: ext_sync > load > counting step > hold, then zero-config clamps
  always_comb begin
    chip_d        = chip_q;
    epoch_d       = epoch_q;
    epoch_pulse_d = 1'b0;
    sec2_pulse_d  = 1'b0;
    cfg_err_d     = cfg_err_q | chips_zero | epochs_zero;

    if (sync_hit) begin
      chip_d        = '0;
      epoch_d       = '0;
      epoch_pulse_d = 1'b1;
      sec2_pulse_d  = 1'b1;
    end else if (bus.load) begin
      if (bus.load_chip >= bus.chips_per_epoch) begin
        chip_d    = '0;
        cfg_err_d = 1'b1;
      end else begin
        chip_d = bus.load_chip;
      end
      if (bus.load_epoch >= bus.epochs_per_sec2) begin
        epoch_d   = '0;
        cfg_err_d = 1'b1;
      end else begin
        epoch_d = bus.load_epoch;
      end
    end else if (bus.enable && bus.chip_pulse && !chips_zero) begin
      // >= rather than == so a config shrink mid-run wraps on the next chip
      if (chip_q >= chip_last) begin
        chip_d        = '0;
        epoch_pulse_d = 1'b1;
        if (epochs_zero) begin
          epoch_d = '0;
        end else if (epoch_q >= epoch_last) begin
          epoch_d      = '0;
          sec2_pulse_d = 1'b1;
        end else begin
          epoch_d = epoch_q + EpochOne;
        end
      end else begin
        chip_d = chip_q + ChipOne;
      end
    end

    if (chips_zero) begin
      chip_d = '0;
    end
    if (epochs_zero) begin
      epoch_d = '0;
    end
  end

  // State and registered pulse outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chip_q        <= '0;
      epoch_q       <= '0;
      epoch_pulse_q <= 1'b0;
      sec2_pulse_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      chip_q        <= chip_d;
      epoch_q       <= epoch_d;
      epoch_pulse_q <= epoch_pulse_d;
      sec2_pulse_q  <= sec2_pulse_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign bus.epoch_pulse = epoch_pulse_q;
  assign bus.sec2_pulse  = sec2_pulse_q;
  assign bus.chip_idx    = chip_q;
  assign bus.epoch_idx   = epoch_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_imi_epoch_gen.sv
// Testbench for imi_epoch_gen: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model held in integers.
module tb_imi_epoch_gen;

  localparam int CW = 16;
  localparam int EW = 12;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model state
  int cfgC = 4;
  int cfgE = 3;
  int mChip = 0;
  int mEpoch = 0;
  bit mEp = 0;
  bit mS2 = 0;
  bit mErr = 0;

  always #5 clk = ~clk;

  imi_epoch_gen_if #(.CHIP_CNT_W(CW), .EPOCH_CNT_W(EW)) bus ();

  imi_epoch_gen #(.CHIP_CNT_W(CW), .EPOCH_CNT_W(EW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Configuration update, visible to DUT and model from the next edge
  task automatic setCfg(input int c, input int e);
    cfgC = c;
    cfgE = e;
    bus.chips_per_epoch = CW'(c);
    bus.epochs_per_sec2 = EW'(e);
  endtask

  // One clock: apply inputs, advance model at the edge, settle 1 ns after it
  task automatic drive_cycle(input bit en, input bit cp, input bit ld,
                             input int lc, input int le, input bit es);
    bit esEff;
    bit ep;
    bit s2;
    bus.enable     = en;
    bus.chip_pulse = cp;
    bus.load       = ld;
    bus.load_chip  = CW'(lc);
    bus.load_epoch = EW'(le);
`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
    bus.ext_sync = es;
    esEff = es;
`else
    esEff = 1'b0;
`endif
    @(posedge clk);
    ep = 0;
    s2 = 0;
    if (esEff) begin
      mChip = 0; mEpoch = 0; ep = 1; s2 = 1;
    end else if (ld) begin
      if (lc < cfgC) mChip = lc; else begin mChip = 0; mErr = 1; end
      if (le < cfgE) mEpoch = le; else begin mEpoch = 0; mErr = 1; end
    end else if (en && cp && cfgC > 0) begin
      mChip = mChip + 1;
      if (mChip >= cfgC) begin
        mChip = 0;
        ep = 1;
        if (cfgE > 0) begin
          mEpoch = mEpoch + 1;
          if (mEpoch >= cfgE) begin mEpoch = 0; s2 = 1; end
        end
      end
    end
    if (cfgC == 0) begin mChip = 0; mErr = 1; end
    if (cfgE == 0) begin mEpoch = 0; mErr = 1; end
    mEp = ep;
    mS2 = s2;
    #1;
    bus.chip_pulse = 1'b0;
    bus.load       = 1'b0;
`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
    bus.ext_sync = 1'b0;
`endif
  endtask

  task automatic test_reset();
    setCfg(4, 3);
    bus.enable = 0; bus.chip_pulse = 0; bus.load = 0;
    bus.load_chip = '0; bus.load_epoch = '0;
`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
    bus.ext_sync = 0;
`endif
    resetn = 1'b0;
    #23;
    nChecks += 5;
    if (bus.chip_idx !== '0) begin nFails++; $display("[TB] FAIL reset_chip got %0d want 0", bus.chip_idx); end
    if (bus.epoch_idx !== '0) begin nFails++; $display("[TB] FAIL reset_epoch got %0d want 0", bus.epoch_idx); end
    if (bus.epoch_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL reset_epoch_pulse got %b want 0", bus.epoch_pulse); end
    if (bus.sec2_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL reset_sec2_pulse got %b want 0", bus.sec2_pulse); end
    if (bus.cfg_err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_cfg_err got %b want 0", bus.cfg_err); end
    @(negedge clk);
    resetn = 1'b1;
    drive_cycle(0, 0, 0, 0, 0, 0);
    nChecks += 2;
    if (bus.chip_idx !== '0) begin nFails++; $display("[TB] FAIL post_reset_chip got %0d want 0", bus.chip_idx); end
    if (bus.epoch_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL post_reset_pulse got %b want 0", bus.epoch_pulse); end
  endtask

  // Config 4/3, chip_pulse every other cycle, 12 chips
  task automatic test_basic();
    int seen = 0;
    int epCnt = 0;
    int s2Cnt = 0;
    int wantIdx[4] = '{1, 2, 3, 0};
    bit cp;
    for (int i = 0; i < 24; i++) begin
      cp = (i % 2 == 1);
      drive_cycle(1, cp, 0, 0, 0, 0);
      if (cp) seen++;
      if (bus.epoch_pulse === 1'b1) epCnt++;
      if (bus.sec2_pulse === 1'b1) s2Cnt++;
      nChecks += 3;
      if (bus.epoch_pulse !== (cp && seen % 4 == 0)) begin nFails++; $display("[TB] FAIL basic_epoch_pulse cyc %0d got %b want %b", i, bus.epoch_pulse, cp && seen % 4 == 0); end
      if (bus.sec2_pulse !== (cp && seen == 12)) begin nFails++; $display("[TB] FAIL basic_sec2_pulse cyc %0d got %b want %b", i, bus.sec2_pulse, cp && seen == 12); end
      if (bus.epoch_idx !== EW'((seen / 4) % 3)) begin nFails++; $display("[TB] FAIL basic_epoch_idx cyc %0d got %0d want %0d", i, bus.epoch_idx, (seen / 4) % 3); end
      if (cp && seen <= 4) begin
        nChecks++;
        if (bus.chip_idx !== CW'(wantIdx[seen-1])) begin nFails++; $display("[TB] FAIL basic_chip_seq chip %0d got %0d want %0d", seen, bus.chip_idx, wantIdx[seen-1]); end
      end
    end
    nChecks += 2;
    if (epCnt != 3) begin nFails++; $display("[TB] FAIL basic_epoch_count got %0d want 3", epCnt); end
    if (s2Cnt != 1) begin nFails++; $display("[TB] FAIL basic_sec2_count got %0d want 1", s2Cnt); end
  endtask

  // Config 1/2, chip_pulse every cycle
  task automatic test_back_to_back();
    setCfg(1, 2);
    drive_cycle(1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      drive_cycle(1, 1, 0, 0, 0, 0);
      nChecks += 4;
      if (bus.epoch_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_epoch_pulse k %0d got %b want 1", k, bus.epoch_pulse); end
      if (bus.sec2_pulse !== (k % 2 == 0)) begin nFails++; $display("[TB] FAIL b2b_sec2_pulse k %0d got %b want %b", k, bus.sec2_pulse, k % 2 == 0); end
      if (bus.chip_idx !== '0) begin nFails++; $display("[TB] FAIL b2b_chip_idx k %0d got %0d want 0", k, bus.chip_idx); end
      if (bus.epoch_idx !== EW'(k % 2)) begin nFails++; $display("[TB] FAIL b2b_epoch_idx k %0d got %0d want %0d", k, bus.epoch_idx, k % 2); end
    end
  endtask

  // Load 2/2 with coincident chip_pulse, then two chips
  task automatic test_load();
    setCfg(4, 3);
    drive_cycle(1, 1, 1, 2, 2, 0);
    nChecks += 4;
    if (bus.epoch_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL load_no_pulse got %b want 0", bus.epoch_pulse); end
    if (bus.sec2_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL load_no_sec2 got %b want 0", bus.sec2_pulse); end
    if (bus.chip_idx !== CW'(2)) begin nFails++; $display("[TB] FAIL load_chip got %0d want 2", bus.chip_idx); end
    if (bus.epoch_idx !== EW'(2)) begin nFails++; $display("[TB] FAIL load_epoch got %0d want 2", bus.epoch_idx); end
    drive_cycle(1, 1, 0, 0, 0, 0);
    nChecks += 2;
    if (bus.chip_idx !== CW'(3)) begin nFails++; $display("[TB] FAIL load_chip1 got %0d want 3", bus.chip_idx); end
    if (bus.epoch_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL load_chip1_pulse got %b want 0", bus.epoch_pulse); end
    drive_cycle(1, 1, 0, 0, 0, 0);
    nChecks += 4;
    if (bus.epoch_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL load_chip2_epoch got %b want 1", bus.epoch_pulse); end
    if (bus.sec2_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL load_chip2_sec2 got %b want 1", bus.sec2_pulse); end
    if (bus.chip_idx !== '0) begin nFails++; $display("[TB] FAIL load_chip2_idx got %0d want 0", bus.chip_idx); end
    if (bus.epoch_idx !== '0) begin nFails++; $display("[TB] FAIL load_chip2_epoch_idx got %0d want 0", bus.epoch_idx); end
  endtask

  // enable low freezes phase at chip 3; re-enable wraps on first chip
  task automatic test_enable();
    drive_cycle(1, 0, 1, 3, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 1, 0, 0, 0, 0);
      nChecks += 2;
      if (bus.epoch_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL en_off_pulse i %0d got %b want 0", i, bus.epoch_pulse); end
      if (bus.chip_idx !== CW'(3)) begin nFails++; $display("[TB] FAIL en_off_chip i %0d got %0d want 3", i, bus.chip_idx); end
    end
    drive_cycle(1, 1, 0, 0, 0, 0);
    nChecks += 3;
    if (bus.epoch_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL en_on_pulse got %b want 1", bus.epoch_pulse); end
    if (bus.chip_idx !== '0) begin nFails++; $display("[TB] FAIL en_on_chip got %0d want 0", bus.chip_idx); end
    if (bus.epoch_idx !== EW'(1)) begin nFails++; $display("[TB] FAIL en_on_epoch got %0d want 1", bus.epoch_idx); end
  endtask

`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
  // ext_sync zeroes indices and fires both pulses, beating a coincident load
  task automatic test_ext_sync();
    drive_cycle(1, 0, 1, 2, 1, 0);
    drive_cycle(0, 0, 1, 3, 2, 1);
    nChecks += 4;
    if (bus.epoch_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL sync_epoch_pulse got %b want 1", bus.epoch_pulse); end
    if (bus.sec2_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL sync_sec2_pulse got %b want 1", bus.sec2_pulse); end
    if (bus.chip_idx !== '0) begin nFails++; $display("[TB] FAIL sync_chip got %0d want 0", bus.chip_idx); end
    if (bus.epoch_idx !== '0) begin nFails++; $display("[TB] FAIL sync_epoch got %0d want 0", bus.epoch_idx); end
  endtask
`endif

  // Out-of-range load sets the sticky error
  task automatic test_cfg_err();
    nChecks++;
    if (bus.cfg_err !== 1'b0) begin nFails++; $display("[TB] FAIL err_clean got %b want 0", bus.cfg_err); end
    drive_cycle(1, 0, 1, 7, 1, 0);
    nChecks += 3;
    if (bus.chip_idx !== '0) begin nFails++; $display("[TB] FAIL err_chip got %0d want 0", bus.chip_idx); end
    if (bus.epoch_idx !== EW'(1)) begin nFails++; $display("[TB] FAIL err_epoch got %0d want 1", bus.epoch_idx); end
    if (bus.cfg_err !== 1'b1) begin nFails++; $display("[TB] FAIL err_set got %b want 1", bus.cfg_err); end
    drive_cycle(1, 0, 1, 1, 1, 0);
    nChecks += 2;
    if (bus.chip_idx !== CW'(1)) begin nFails++; $display("[TB] FAIL err_valid_chip got %0d want 1", bus.chip_idx); end
    if (bus.cfg_err !== 1'b1) begin nFails++; $display("[TB] FAIL err_sticky got %b want 1", bus.cfg_err); end
  endtask

  // Zero configs: no chip counting at 0 chips; epochs=0 keeps epoch pulses only
  task automatic test_zero_cfg();
    setCfg(0, 3);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 1, 0, 0, 0, 0);
      nChecks += 2;
      if (bus.chip_idx !== '0) begin nFails++; $display("[TB] FAIL zc_chip i %0d got %0d want 0", i, bus.chip_idx); end
      if (bus.epoch_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL zc_pulse i %0d got %b want 0", i, bus.epoch_pulse); end
    end
    setCfg(2, 0);
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1, 1, 0, 0, 0, 0);
      nChecks += 3;
      if (bus.epoch_pulse !== (i % 2 == 0)) begin nFails++; $display("[TB] FAIL ze_pulse i %0d got %b want %b", i, bus.epoch_pulse, i % 2 == 0); end
      if (bus.sec2_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL ze_sec2 i %0d got %b want 0", i, bus.sec2_pulse); end
      if (bus.epoch_idx !== '0) begin nFails++; $display("[TB] FAIL ze_epoch i %0d got %0d want 0", i, bus.epoch_idx); end
    end
  endtask

  // Random traffic with periodic random reconfiguration
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) setCfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      drive_cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 19) == 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0));
      nChecks += 5;
      if (bus.chip_idx !== CW'(mChip)) begin nFails++; $display("[TB] FAIL rnd_chip cyc %0d got %0d want %0d", i, bus.chip_idx, mChip); end
      if (bus.epoch_idx !== EW'(mEpoch)) begin nFails++; $display("[TB] FAIL rnd_epoch cyc %0d got %0d want %0d", i, bus.epoch_idx, mEpoch); end
      if (bus.epoch_pulse !== mEp) begin nFails++; $display("[TB] FAIL rnd_epoch_pulse cyc %0d got %b want %b", i, bus.epoch_pulse, mEp); end
      if (bus.sec2_pulse !== mS2) begin nFails++; $display("[TB] FAIL rnd_sec2_pulse cyc %0d got %b want %b", i, bus.sec2_pulse, mS2); end
      if (bus.cfg_err !== mErr) begin nFails++; $display("[TB] FAIL rnd_cfg_err cyc %0d got %b want %b", i, bus.cfg_err, mErr); end
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_load();
    test_enable();
`ifdef IMI_EPOCH_GEN_EXT_SYNC_EN
    test_ext_sync();
`endif
    test_cfg_err();
    test_zero_cfg();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
